// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns per clock; the mode is chosen per transaction.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         iClk,
   input  logic         iRst_n,
   input  logic         iValid,
   output logic         oReady,
   input  logic         iInv,
   input  logic [127:0] iData,
   output logic         oValid,
   input  logic         iReady,
   output logic [127:0] oData
);

   localparam int         N    = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST = 2'(N - 1);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       r_state, w_next_state;
   logic [127:0] r_work, r_oData, w_mixed;
   logic         r_inv;
   logic [1:0]   r_cnt;
   logic         w_accept, w_last;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Single column transform shared by every column slot; products via xt chains.
   function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
      logic [7:0] b [4];
      logic [7:0] m2 [4], m3 [4], m9 [4], mb [4], md [4], me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         b[i]  = a[31-8*i -: 8];
         x2    = xt(b[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m2[i] = x2;
         m3[i] = x2 ^ b[i];
         m9[i] = x8 ^ b[i];
         mb[i] = x8 ^ x2 ^ b[i];
         md[i] = x8 ^ x4 ^ b[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      if (!inv)
         return {m2[0] ^ m3[1] ^ b[2]  ^ b[3],
                 b[0]  ^ m2[1] ^ m3[2] ^ b[3],
                 b[0]  ^ b[1]  ^ m2[2] ^ m3[3],
                 m3[0] ^ b[1]  ^ b[2]  ^ m2[3]};
      else
         return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Only the columns of the current group are rewritten; the rest pass through.
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_col
         localparam logic [1:0] GRP = 2'(g / COLS_PER_CYCLE);
         assign w_mixed[127-32*g -: 32] = (r_cnt == GRP) ? mix_col(r_work[127-32*g -: 32], r_inv)
                                                         : r_work[127-32*g -: 32];
      end
   endgenerate

   assign w_accept = iValid && oReady;
   assign w_last   = (r_cnt == LAST);

   always_ff @(posedge iClk) begin
      if (!iRst_n) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = BUSY;
         BUSY:    if (w_last)   w_next_state = DONE;
         DONE:    if (iReady)   w_next_state = w_accept ? BUSY : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      oReady = (r_state == IDLE) || (r_state == DONE && iReady);
      oValid = (r_state == DONE);
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_work  <= '0;
         r_inv   <= 1'b0;
         r_cnt   <= '0;
         r_oData <= '0;
      end else if (w_accept) begin
         r_work <= iData;
         r_inv  <= iInv;
         r_cnt  <= '0;
      end else if (r_state == BUSY) begin
         r_work <= w_mixed;
         r_cnt  <= r_cnt + 2'd1;
         if (w_last) r_oData <= w_mixed;
      end
   end

   assign oData = r_oData;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance per legal COLS_PER_CYCLE, checked
// against a matrix-product model built on a generic GF(2^8) multiply.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         vld_i [3];
   logic         rdy_o [3];
   logic         inv_i [3];
   logic [127:0] dat_i [3];
   logic         vld_o [3];
   logic         rdy_i [3];
   logic [127:0] dat_o [3];

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   genvar gk;
   generate
      for (gk = 0; gk < 3; gk++) begin : g_dut
         mix_columns_seq #(.COLS_PER_CYCLE(1 << gk)) u_dut (
            .iClk(clk), .iRst_n(rst_n),
            .iValid(vld_i[gk]), .oReady(rdy_o[gk]), .iInv(inv_i[gk]), .iData(dat_i[gk]),
            .oValid(vld_o[gk]), .iReady(rdy_i[gk]), .oData(dat_o[gk]));
      end
   endgenerate

   // Shift-and-add GF(2^8) multiply, modulus x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
      return p[7:0];
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0] fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
      logic [7:0] bwd [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] r = '0;
      logic [7:0] acc, co;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               co  = inv ? bwd[(j - row + 4) % 4] : fwd[(j - row + 4) % 4];
               acc ^= gmul(co, s[127 - 8*(4*c + j) -: 8]);
            end
            r[127 - 8*(4*c + row) -: 8] = acc;
         end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present a state, wait for accept, then scramble inputs while it is in flight.
   task automatic send(input int k, input logic [127:0] d, input logic inv);
      int t = 0;
      vld_i[k] = 1'b1; dat_i[k] = d; inv_i[k] = inv;
      while (!rdy_o[k] && t < 50) begin tick(); t++; end
      chk("accept_timeout", 128'(t < 50), 128'd1);
      tick();
      vld_i[k] = 1'b0; inv_i[k] = ~inv; dat_i[k] = {4{$urandom}};
   endtask

   task automatic wait_result(input int k, output logic [127:0] res, output int lat);
      lat = 0;
      do begin tick(); lat++; end while (!vld_o[k] && lat < 20);
      res = dat_o[k];
   endtask

   task automatic txn(input int k, input logic [127:0] d, input logic inv, output logic [127:0] res);
      int lat;
      rdy_i[k] = 1'b1;
      send(k, d, inv);
      wait_result(k, res, lat);
      chk($sformatf("latency_k%0d", k), 128'(lat), 128'(4 >> k));
      chk($sformatf("data_k%0d", k), res, model(d, inv));
      tick();
   endtask

   localparam logic [127:0] V_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] C_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] C_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

   initial begin
      logic [127:0] res, res2, held, orig;
      int lat;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vld_i[k] = 1'b0; inv_i[k] = 1'b0; dat_i[k] = '0; rdy_i[k] = 1'b1;
      end
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         chk("reset_ovalid", 128'(vld_o[k]), 128'd0);
         chk("reset_odata", dat_o[k], 128'd0);
         chk("reset_oready", 128'(rdy_o[k]), 128'd1);
      end
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 3; k++) begin
         // Known-answer vectors
         txn(k, V_IN, 1'b0, res);  chk("fips_fwd", res, V_OUT);
         txn(k, V_OUT, 1'b1, res); chk("fips_inv", res, V_IN);
         txn(k, C_IN, 1'b0, res);  chk("col_fwd", res, C_OUT);

         // Backpressure then same-edge handoff + accept
         rdy_i[k] = 1'b0;
         send(k, V_IN, 1'b0);
         wait_result(k, held, lat);
         chk("bp_latency", 128'(lat), 128'(4 >> k));
         for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", dat_o[k], held);
            chk("bp_hold_valid", 128'(vld_o[k]), 128'd1);
            chk("bp_oready_low", 128'(rdy_o[k]), 128'd0);
         end
         rdy_i[k] = 1'b1; vld_i[k] = 1'b1; dat_i[k] = C_IN; inv_i[k] = 1'b0;
         #1;
         chk("b2b_oready", 128'(rdy_o[k]), 128'd1);
         tick();
         vld_i[k] = 1'b0; inv_i[k] = 1'b1;
         chk("b2b_valid_drop", 128'(vld_o[k]), 128'd0);
         wait_result(k, res, lat);
         chk("b2b_latency", 128'(lat), 128'(4 >> k));
         chk("b2b_data", res, C_OUT);
         tick();
      end

      // Reset in BUSY with one column per cycle, counter at 2
      rdy_i[0] = 1'b1;
      send(0, V_IN, 1'b0);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_ovalid", 128'(vld_o[0]), 128'd0);
      chk("midrst_odata", dat_o[0], 128'd0);
      chk("midrst_oready", 128'(rdy_o[0]), 128'd1);
      rst_n = 1'b1;
      txn(0, V_IN, 1'b0, res); chk("midrst_fresh", res, V_OUT);

      // Random round trips
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 200; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            txn(k, orig, 1'b0, res);
            txn(k, res, 1'b1, res2);
            chk("roundtrip", res2, orig);
         end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential, parametrised MixColumns/InvMixColumns engine for the AES datapath on DE10. It accepts one 128-bit state per transaction through a valid/ready handshake. It processes COLS_PER_CYCLE columns per clock, which trades area for latency. The forward or inverse transform is selected per transaction, so one instance serves both the encrypt and decrypt round pipelines.

Parameters:
COLS_PER_CYCLE, 1, number of 32-bit columns transformed per clock; legal values are 1, 2 and 4; any other value is a compile-time error.

Ports:
iClk  input  1  system clock; all logic is on the rising edge.
iRst_n  input  1  reset, synchronous, active-low.
iValid  input  1  input state available.
oReady  output  1  engine can accept an input this cycle.
iInv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept.
iData  input  128  input state; byte k = iData[127-8k -: 8]; column c = bytes 4c..4c+3 (FIPS-197 column-major order, byte 0 is the MSB).
oValid  output  1  result available.
iReady  input  1  downstream accepts the result.
oData  output  128  result state, same byte order as iData.

Behaviour:
- Reset: when iRst_n=0 at a rising edge, the engine goes to IDLE and sets oValid=0, oData=0, the column counter to 0 and the latched mode to 0. Reset mid-transaction discards the transaction; no partial result is ever presented.
- N = 4/COLS_PER_CYCLE compute cycles (4, 2 or 1).
- FSM states: IDLE, BUSY, DONE.
- oReady = (state==IDLE) || (state==DONE && iReady). This combinational path allows back-to-back transactions.
- Accept: occurs at the edge where iValid && oReady. On accept, latch iData into the work register, latch iInv into the mode register, clear the counter, and go to BUSY. In the DONE-and-iReady case, the result handoff and the new accept happen at the same edge.
- BUSY: each edge transforms columns counter*C .. counter*C+C-1 of the work register in place (C = COLS_PER_CYCLE), lowest column index first, then increments the counter.
- BUSY completion: at the edge that processes the last column group, copy the complete result into oData, set oValid=1 and go to DONE. The accept-edge to oValid-high latency is exactly N cycles.
- DONE: oValid=1 and oData is held stable while iReady=0. At an edge with iReady=1, the result is consumed:
  - with no new accept, oValid goes to 0 and the FSM returns to IDLE;
  - with a simultaneous accept, the FSM goes to BUSY and oValid goes to 0.
- oData is written only at completion and holds its value otherwise, including after oValid falls.
- iValid while busy is ignored; the upstream block must hold iData, iValid and iInv until oReady.
- Changes to iInv or iData after accept have no effect on the transaction in flight.
- Forward column transform, with xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 0):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse column transform uses coefficients 0e/0b/0d/09 in the same circulant arrangement. GF(2^8) products are built by repeated xt and XOR; no multipliers and no lookup ROM.
- Every instantiation of COLS_PER_CYCLE shares one column-transform function; no behaviour other than latency depends on the parameter.

Test Plan:
- Forward FIPS-197 vector: iInv=0, iData=d4bf5d30e0b452aeb84111f11e2798e5 -> oData=046681e5e0cb199a48f8d37a2806264c, with oValid exactly N cycles after accept. Run for COLS_PER_CYCLE=1, 2 and 4.
- Inverse vector: iInv=1, iData=046681e5e0cb199a48f8d37a2806264c -> oData=d4bf5d30e0b452aeb84111f11e2798e5.
- Per-column vectors: iData=db135345f20a225c01010101c6c6c6c6 with iInv=0 -> oData=8e4da1bc9fdc589d01010101c6c6c6c6.
- Backpressure and back-to-back:
  - Hold iReady=0 for 5 cycles after oValid; oData must stay constant and oReady must be 0.
  - Then raise iReady together with iValid and a new state; the handoff and accept must occur at the same edge, and the second result must appear N cycles later.
- Reset mid-operation: assert iRst_n=0 while in BUSY, with COLS_PER_CYCLE=1 and counter=2. The next edge must give oValid=0, oData=0 and oReady=1. A fresh transaction then completes with the correct result.
- Randomised round-trip: 200 random states, each sent forward and its result sent inverse; every second result must equal the original input. Check that iInv toggled after accept does not alter the in-flight result.
